// File: rtl/carfield_periph_pkg.sv
// carfield_periph_pkg
// Shared definitions for the Carfield peripheral-window demultiplexer:
//   - base addresses of the five 4 KiB peripheral pages
//   - page size and the derived page-offset width
//   - target-index and FSM state enums
//   - periphBase() helper mapping a target index to its page base
// Optional feature macro used by the block: CARFIELD_PERIPH_TIMEOUT_EN.
package carfield_periph_pkg;

   localparam int NumPeriphTgt = 5;

   localparam logic [63:0] PeriphPageSize = 64'h1000;
   localparam int          PageOffsW      = $clog2(PeriphPageSize);

   // Page bases as laid out in the Carfield address map
   localparam logic [63:0] CanBase         = 64'h0000_0000_2000_1000;
   localparam logic [63:0] SysTimerBase    = 64'h0000_0000_2000_4000;
   localparam logic [63:0] AdvTimerBase    = 64'h0000_0000_2000_5000;
   localparam logic [63:0] WatchdogBase    = 64'h0000_0000_2000_7000;
   localparam logic [63:0] HyperBusCfgBase = 64'h0000_0000_2000_9000;

   typedef enum logic [2:0] {
      TgtCan      = 3'd0,
      TgtSysTimer = 3'd1,
      TgtAdvTimer = 3'd2,
      TgtWatchdog = 3'd3,
      TgtHyperBus = 3'd4
   } tgt_idx_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   // Page base of a target; bit i of any per-target vector belongs to index i
   function automatic logic [63:0] periphBase(input tgt_idx_e idx);
      case (idx)
         TgtCan:      periphBase = CanBase;
         TgtSysTimer: periphBase = SysTimerBase;
         TgtAdvTimer: periphBase = AdvTimerBase;
         TgtWatchdog: periphBase = WatchdogBase;
         default:     periphBase = HyperBusCfgBase;
      endcase
   endfunction

endpackage

// File: rtl/carfield_periph_addr_decode.sv
// carfield_periph_addr_decode
// Purely combinational page decoder for the peripheral window.
// Ports:
//   page_i  - request address with the 12-bit page offset stripped
//   hit_o   - address falls on an enabled target page
//   sel_o   - one-hot target select (all zero on a miss)
// Disabled targets never match, so their pages decode exactly like holes.
module carfield_periph_addr_decode
   import carfield_periph_pkg::*;
#(
   parameter int unsigned             AddrWidth = 64,
   parameter logic [NumPeriphTgt-1:0] TgtEnable = 5'b11110
) (
   input  logic [AddrWidth-PageOffsW-1:0] page_i,
   output logic                           hit_o,
   output logic [NumPeriphTgt-1:0]        sel_o
);

   localparam int PageW = AddrWidth - PageOffsW;

   // Full upper-address compare against every page base so that aliases
   // outside the 32-bit window can never hit
   always_comb begin
      sel_o = '0;
      for (int i = 0; i < NumPeriphTgt; i++) begin
         sel_o[i] = TgtEnable[i] &&
                    (page_i == PageW'(periphBase(tgt_idx_e'(i)) >> PageOffsW));
      end
   end

   assign hit_o = |sel_o;

endmodule

// File: rtl/carfield_periph_demux.sv
// carfield_periph_demux
// Single-outstanding request demultiplexer for the 0x2000_1000-0x2000_9FFF
// peripheral window. One request is accepted, forwarded to one of five page
// targets and exactly one response is returned upstream.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   req_*_i / req_ready_o        - upstream request channel
//   rsp_*_o / rsp_ready_i        - upstream response channel
//   tgt_req_valid_o/ready_i      - one-hot per-target request handshake
//   tgt_addr/write/wdata/strb_o  - request payload shared by all targets
//   tgt_rsp_valid/rdata/error_i  - per-target response strobe and data
//   timeout_o                    - one-cycle pulse when a target times out
// Macro CARFIELD_PERIPH_TIMEOUT_EN adds the FWD/WAIT timeout counter and the
// poison vector; without it timeout_o is tied low and a silent target hangs.
module carfield_periph_demux
   import carfield_periph_pkg::*;
#(
   parameter int unsigned             AddrWidth     = 64,
   parameter int unsigned             DataWidth     = 32,
   parameter logic [NumPeriphTgt-1:0] TgtEnable     = 5'b11110,
   parameter int unsigned             TimeoutCycles = 256
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   input  logic [AddrWidth-1:0]              req_addr_i,
   input  logic                              req_write_i,
   input  logic [DataWidth-1:0]              req_wdata_i,
   input  logic [DataWidth/8-1:0]            req_strb_i,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [DataWidth-1:0]              rsp_rdata_o,
   output logic                              rsp_error_o,
   output logic [NumPeriphTgt-1:0]           tgt_req_valid_o,
   input  logic [NumPeriphTgt-1:0]           tgt_req_ready_i,
   output logic [PageOffsW-1:0]              tgt_addr_o,
   output logic                              tgt_write_o,
   output logic [DataWidth-1:0]              tgt_wdata_o,
   output logic [DataWidth/8-1:0]            tgt_strb_o,
   input  logic [NumPeriphTgt-1:0]           tgt_rsp_valid_i,
   input  logic [NumPeriphTgt*DataWidth-1:0] tgt_rdata_i,
   input  logic [NumPeriphTgt-1:0]           tgt_error_i,
   output logic                              timeout_o
);

   if (TimeoutCycles < 2) begin : gen_bad_timeout
      $error("TimeoutCycles must be at least 2");
   end

   state_e                   state_q, state_d;
   logic                     req_ready_q, req_ready_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                     rsp_error_q, rsp_error_d;
   logic [NumPeriphTgt-1:0]  tgt_valid_q, tgt_valid_d;
   logic [NumPeriphTgt-1:0]  sel_q, sel_d;
   logic [PageOffsW-1:0]     addr_q, addr_d;
   logic                     write_q, write_d;
   logic [DataWidth-1:0]     wdata_q, wdata_d;
   logic [DataWidth/8-1:0]   strb_q, strb_d;

   logic                     dec_hit;
   logic [NumPeriphTgt-1:0]  dec_sel;
   logic                     poisoned;
   logic [DataWidth-1:0]     sel_rdata;
   logic                     sel_error;

   carfield_periph_addr_decode #(
      .AddrWidth (AddrWidth),
      .TgtEnable (TgtEnable)
   ) u_addr_decode (
      .page_i (req_addr_i[AddrWidth-1:PageOffsW]),
      .hit_o  (dec_hit),
      .sel_o  (dec_sel)
   );

`ifdef CARFIELD_PERIPH_TIMEOUT_EN
   localparam int CntWidth = $clog2(TimeoutCycles) + 1;

   logic [CntWidth-1:0]      cnt_q, cnt_d;
   logic [NumPeriphTgt-1:0]  poison_q, poison_d;
   logic                     timeout_q, timeout_d;

   // A poisoned target may still owe a stale response, so it is never
   // forwarded to again until reset
   assign poisoned  = |(dec_sel & poison_q);
   assign timeout_o = timeout_q;
`else
   assign poisoned  = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Response mux driven by the latched select, so strobes from targets
   // other than the one in flight can never leak upstream
   always_comb begin
      sel_rdata = '0;
      sel_error = 1'b0;
      for (int i = 0; i < NumPeriphTgt; i++) begin
         if (sel_q[i]) begin
            sel_rdata = sel_rdata | tgt_rdata_i[i*DataWidth +: DataWidth];
            sel_error = sel_error | tgt_error_i[i];
         end
      end
   end

   // Next-state logic; every output is then derived from the next state so
   // the registered outputs line up with the state they describe
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
`ifdef CARFIELD_PERIPH_TIMEOUT_EN
      cnt_d       = cnt_q;
      poison_d    = poison_q;
      timeout_d   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_q) begin
               sel_d   = dec_sel;
               addr_d  = req_addr_i[PageOffsW-1:0];
               write_d = req_write_i;
               wdata_d = req_wdata_i;
               strb_d  = req_strb_i;
               if (dec_hit && !poisoned) begin
                  state_d = FWD;
               end else begin
                  state_d     = RESP;
                  rsp_rdata_d = '0;
                  rsp_error_d = 1'b1;
               end
            end
         end
         FWD: begin
            if (|(tgt_req_ready_i & sel_q)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (|(tgt_rsp_valid_i & sel_q)) begin
               state_d     = RESP;
               rsp_error_d = sel_error;
               rsp_rdata_d = sel_error ? '0 : sel_rdata;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef CARFIELD_PERIPH_TIMEOUT_EN
      // The counter spans FWD and WAIT together; a timeout only fires when
      // the cycle made no progress, so a completion on the last cycle wins
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == FWD || state_q == WAIT) begin
         cnt_d = cnt_q + CntWidth'(1);
         if (state_d == state_q && cnt_q >= CntWidth'(TimeoutCycles - 1)) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
            timeout_d   = 1'b1;
            poison_d    = poison_q | sel_q;
         end
      end
`endif

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      tgt_valid_d = (state_d == FWD) ? sel_d : '0;
   end

   // State, request and output registers, all cleared by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
         tgt_valid_q <= '0;
         sel_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         strb_q      <= '0;
`ifdef CARFIELD_PERIPH_TIMEOUT_EN
         cnt_q       <= '0;
         poison_q    <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
         tgt_valid_q <= tgt_valid_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
`ifdef CARFIELD_PERIPH_TIMEOUT_EN
         cnt_q       <= cnt_d;
         poison_q    <= poison_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign req_ready_o     = req_ready_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rsp_rdata_q;
   assign rsp_error_o     = rsp_error_q;
   assign tgt_req_valid_o = tgt_valid_q;
   assign tgt_addr_o      = addr_q;
   assign tgt_write_o     = write_q;
   assign tgt_wdata_o     = wdata_q;
   assign tgt_strb_o      = strb_q;

endmodule
